// File: rtl/sm_pkg.sv
// sm_pkg: base encodings, channel state enum and width helpers shared by the feeder
package sm_pkg;
  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;
  typedef enum logic {CH_IDLE, CH_FEED} ch_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo.sv
// fifo: synchronous FIFO, ports: push/din write, pop/dout read (dout is the head), empty, full; DEPTH power of 2, >=2
module fifo
  import sm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/sm_feeder_n.sv
// sm_feeder_n: interleaved multi-channel target-sequence feeder for a scoring array
// Ports: clk/rst (sync, active-high); ld + feed_in {ID, LENGTH, TARGET} load a free channel
// (ld_ready / full = ~ld_ready); ch_sel picks the channel whose base appears on data_out and
// which advances; en = per-channel feed active; re pops per-channel ID FIFOs (id_out heads,
// id_valid non-empty). Optional SM_FEEDER_ERR_EN adds sticky err_ovf / err_clamp outputs.
module sm_feeder_n
  import sm_pkg::*;
#(
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH = 12,
  parameter int ID_WIDTH = 48,
  parameter int CHANNELS = 4,
  parameter int ID_FIFO_DEPTH = 4,
  localparam int IN_WIDTH = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH,
  localparam int CH_W = clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld,
  input  logic [IN_WIDTH-1:0]          feed_in,
  output logic                         ld_ready,
  input  logic [CH_W-1:0]              ch_sel,
  output logic [CHANNELS-1:0]          en,
  output logic [1:0]                   data_out,
  input  logic [CHANNELS-1:0]          re,
  output logic [CHANNELS*ID_WIDTH-1:0] id_out,
  output logic [CHANNELS-1:0]          id_valid,
  output logic                         full
`ifdef SM_FEEDER_ERR_EN
  ,
  output logic                         err_ovf,
  output logic                         err_clamp
`endif
);
  localparam int TW = 2 * TARGET_LENGTH;
  localparam logic [LEN_WIDTH-1:0] TL = LEN_WIDTH'(TARGET_LENGTH);
  logic [ID_WIDTH-1:0] id_in;
  logic [LEN_WIDTH-1:0] len_in, len_clamped;
  logic [TW-1:0] tgt_in;
  ch_state_t st [CHANNELS];
  logic [TW-1:0] tgt [CHANNELS];
  logic [LEN_WIDTH-1:0] cnt [CHANNELS];
  logic [LEN_WIDTH-1:0] len [CHANNELS];
  logic [CHANNELS-1:0] elig, grant, fifo_full, fifo_empty;
  logic load;
  assign {id_in, len_in, tgt_in} = feed_in;
  assign len_clamped = len_in > TL ? TL : len_in;
  assign ld_ready = |elig;
  assign full = ~ld_ready;
  assign load = ld & ld_ready;
  // isolate the lowest set eligibility bit
  assign grant = elig & (~elig + CHANNELS'(1));
  assign id_valid = ~fifo_empty;
  assign data_out = st[ch_sel] == CH_FEED ? tgt[ch_sel][1:0] : 2'b00;
  genvar k;
  for (k = 0; k < CHANNELS; k++) begin : g_ch
    assign elig[k] = (st[k] == CH_IDLE) & ~fifo_full[k];
    assign en[k] = st[k] == CH_FEED;
    always_ff @(posedge clk) begin
      if (rst) begin
        st[k] <= CH_IDLE;
        tgt[k] <= '0;
        cnt[k] <= '0;
        len[k] <= '0;
      end else if (load & grant[k]) begin
        st[k] <= len_clamped == '0 ? CH_IDLE : CH_FEED;
        tgt[k] <= tgt_in;
        cnt[k] <= '0;
        len[k] <= len_clamped;
      end else if (st[k] == CH_FEED && ch_sel == CH_W'(k)) begin
        st[k] <= cnt[k] == len[k] - LEN_WIDTH'(1) ? CH_IDLE : CH_FEED;
        tgt[k] <= tgt[k] >> 2;
        cnt[k] <= cnt[k] + LEN_WIDTH'(1);
      end
    end
    fifo #(.WIDTH(ID_WIDTH), .DEPTH(ID_FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(load & grant[k]),
      .pop(re[k]),
      .din(id_in),
      .dout(id_out[k*ID_WIDTH +: ID_WIDTH]),
      .empty(fifo_empty[k]),
      .full(fifo_full[k])
    );
  end
`ifdef SM_FEEDER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_clamp <= 1'b0;
    end else begin
      err_ovf <= err_ovf | (ld & ~ld_ready);
      err_clamp <= err_clamp | (load & (len_in > TL));
    end
  end
`endif
endmodule

// File: tb/tb_sm_feeder_n.sv
// tb_sm_feeder_n: self-checking bench for sm_feeder_n using a queue-based reference model
module tb_sm_feeder_n;
  localparam int TL = 128, LW = 12, IW = 48, CH = 4, D = 4, CW = 2;
  localparam int IN_W = IW + LW + 2 * TL;
  logic clk = 1'b0;
  logic rst, ld;
  logic [IN_W-1:0] feed_in;
  logic ld_ready, full;
  logic [CW-1:0] ch_sel;
  logic [CH-1:0] en, re, id_valid;
  logic [1:0] data_out;
  logic [CH*IW-1:0] id_out;
`ifdef SM_FEEDER_ERR_EN
  logic err_ovf, err_clamp;
  bit m_ovf, m_clamp;
`endif
  always #5 clk = ~clk;
  sm_feeder_n #(.TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW), .CHANNELS(CH), .ID_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .ld(ld), .feed_in(feed_in), .ld_ready(ld_ready), .ch_sel(ch_sel),
    .en(en), .data_out(data_out), .re(re), .id_out(id_out), .id_valid(id_valid), .full(full)
`ifdef SM_FEEDER_ERR_EN
    , .err_ovf(err_ovf), .err_clamp(err_clamp)
`endif
  );
  int n_vec = 0, n_bad = 0;
  logic [1:0] bq [CH][$];
  logic [IW-1:0] iq [CH][$];
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [IN_W-1:0] mk(input logic [IW-1:0] id, input logic [LW-1:0] l);
    logic [2*TL-1:0] t;
    for (int i = 0; i < 2 * TL; i += 32) t[i +: 32] = $urandom;
    return {id, l, t};
  endfunction
  // compare outputs against the model, then advance one clock and update the model
  task automatic step();
    logic rdy;
    logic [CH-1:0] e_en, e_iv;
    logic [1:0] e_d;
    int sel, n;
    logic [LW-1:0] l;
    #1;
    rdy = 1'b0;
    sel = -1;
    for (int k = 0; k < CH; k++) begin
      e_en[k] = bq[k].size() != 0;
      e_iv[k] = iq[k].size() != 0;
      if (!e_en[k] && iq[k].size() < D && !rdy) begin
        rdy = 1'b1;
        sel = k;
      end
    end
    e_d = e_en[ch_sel] ? bq[ch_sel][0] : 2'b00;
    chk("en", 256'(en), 256'(e_en));
    chk("data_out", 256'(data_out), 256'(e_d));
    chk("ld_ready", 256'(ld_ready), 256'(rdy));
    chk("full", 256'(full), 256'(!rdy));
    chk("id_valid", 256'(id_valid), 256'(e_iv));
    for (int k = 0; k < CH; k++)
      if (e_iv[k]) chk("id_out", 256'(id_out[k*IW +: IW]), 256'(iq[k][0]));
`ifdef SM_FEEDER_ERR_EN
    chk("err_ovf", 256'(err_ovf), 256'(m_ovf));
    chk("err_clamp", 256'(err_clamp), 256'(m_clamp));
`endif
    @(posedge clk);
    l = feed_in[2*TL +: LW];
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        bq[k].delete();
        iq[k].delete();
      end
`ifdef SM_FEEDER_ERR_EN
      m_ovf = 0;
      m_clamp = 0;
`endif
    end else begin
      if (bq[ch_sel].size() != 0) void'(bq[ch_sel].pop_front());
      for (int k = 0; k < CH; k++)
        if (re[k] && iq[k].size() != 0) void'(iq[k].pop_front());
      if (ld && sel >= 0) begin
        n = l > LW'(TL) ? TL : int'(l);
        iq[sel].push_back(feed_in[IN_W-1 -: IW]);
        for (int i = 0; i < n; i++) bq[sel].push_back(feed_in[2*i +: 2]);
      end
`ifdef SM_FEEDER_ERR_EN
      if (ld && !rdy) m_ovf = 1;
      if (ld && rdy && l > LW'(TL)) m_clamp = 1;
`endif
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ld = 1'b0;
    re = '0;
    ch_sel = '0;
    step();
    rst = 1'b0;
  endtask
  typedef struct {bit ld; logic en0; logic [1:0] d; logic iv0;} vec_t;
  vec_t tbl[5];
  initial begin
    rst = 1'b1;
    ld = 1'b0;
    re = '0;
    ch_sel = '0;
    feed_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    // single load: LENGTH 3, bases 1,2,3, ch_sel held at 0
    tbl[0] = '{1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 2'd2, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 1'b1};
    feed_in = '0;
    feed_in[IN_W-1 -: IW] = 48'h123;
    feed_in[2*TL +: LW] = 12'd3;
    feed_in[5:0] = 6'b11_10_01;
    for (int i = 0; i < 5; i++) begin
      ld = tbl[i].ld;
      #1;
      chk("tbl_en0", 256'(en[0]), 256'(tbl[i].en0));
      chk("tbl_data", 256'(data_out), 256'(tbl[i].d));
      chk("tbl_iv0", 256'(id_valid[0]), 256'(tbl[i].iv0));
      step();
    end
    chk("tbl_id0", 256'(id_out[IW-1:0]), 256'(48'h123));
    // four back-to-back loads fill all channels, fifth is rejected
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ld = 1'b1;
      feed_in = mk(IW'(100 + i), 12'd20);
      step();
    end
    ld = 1'b0;
    chk("ready_after4", 256'(ld_ready), 256'(0));
    chk("iv_after4", 256'(id_valid), 256'(4'hF));
    for (int i = 0; i < 3; i++) step();
    // two channels interleaved
    do_reset();
    for (int i = 0; i < 2; i++) begin
      ld = 1'b1;
      ch_sel = 2'd3;
      feed_in = mk(IW'(200 + i), 12'd6);
      step();
    end
    ld = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ch_sel = CW'(i % 2);
      step();
    end
    // zero length, then reload the same channel
    do_reset();
    ld = 1'b1;
    feed_in = mk(IW'(300), 12'd0);
    step();
    ld = 1'b0;
    chk("len0_en", 256'(en), 256'(0));
    ld = 1'b1;
    feed_in = mk(IW'(301), 12'd3);
    step();
    ld = 1'b0;
    chk("len0_reload", 256'(en), 256'(4'b0001));
    for (int i = 0; i < 4; i++) step();
    // over-long length is clamped
    do_reset();
    ld = 1'b1;
    feed_in = mk(IW'(400), LW'(TL + 5));
    step();
    ld = 1'b0;
    for (int i = 0; i < TL + 4; i++) step();
    chk("clamp_done", 256'(en[0]), 256'(0));
    // fill channel 0 FIFO, next load goes to channel 1, then reset mid-feed
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ld = 1'b1;
      feed_in = mk(IW'(500 + i), 12'd0);
      step();
    end
    feed_in = mk(IW'(504), 12'd5);
    step();
    ld = 1'b0;
    chk("fifo_full_ch1", 256'(en), 256'(4'b0010));
    do_reset();
    chk("rst_en", 256'(en), 256'(0));
    chk("rst_iv", 256'(id_valid), 256'(0));
    chk("rst_rdy", 256'(ld_ready), 256'(1));
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 400) == 0;
      ld = $urandom_range(0, 2) == 0;
      feed_in = mk(IW'($urandom),
                   $urandom_range(0, 9) == 0 ? LW'($urandom_range(0, TL + 3)) : LW'($urandom_range(0, 9)));
      ch_sel = CW'($urandom);
      for (int k = 0; k < CH; k++) re[k] = $urandom_range(0, 3) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
